zap_predecode_uop_sequencer: RTL
================================

// Module: zap_predecode_uop_sequencer
// PURPOSE
//  Parametrised LDM/STM/SWP cracker between fetch and decode. Emits one decoded micro-op per cycle
//  (NOP/MOV/ADD/LDR/STR) on explicit fields instead of re-encoded ARM words.
//  Adds over the prior sequencer: ascending-address transfers with per-beat immediate offsets, base
//  writeback as one ADD, writeback suppression when a loaded list contains the base, and a sequence
//  counter.
// PARAMETERS
//  LIST_W  16  register-list width (architectural regs per LDM/STM)
//  REG_W   6   micro-op register index width (extended, includes dummy/user-bank regs)
//  DUMMY0  16  scratch reg index: base copy / swap temp
//  DUMMY1  17  scratch reg index: PC load target
//  PC_IDX  15  list bit / reg index of PC
//  OFF_W   9   signed byte-offset width; must hold +/-4*LIST_W
// PORTS
//  i_clk            in   1      clock
//  i_reset          in   1      synchronous, active-high reset
//  i_instruction    in   32     ARM instruction from fetch; held stable while o_stall_from_decode=1
//  i_instruction_valid in 1     instruction valid
//  i_irq, i_fiq     in   1      interrupt tags from fetch
//  i_stall          in   1      downstream hold: state/counters frozen, outputs recomputed
//  i_clear          in   1      flush (writeback or ALU branch); wins over i_stall
//  o_uop_valid      out  1      micro-op valid
//  o_uop_op         out  3      0 NOP, 1 MOV rd<=rn, 2 ADD rd<=rn+off, 3 LDR rd<=[rn+off], 4 STR [rn+off]<=rd, 7 PASS (raw instr)
//  o_uop_cc         out  4      condition code (instr[31:28])
//  o_uop_rd         out  REG_W  dest (LDR/MOV/ADD) or store data reg (STR)
//  o_uop_rn         out  REG_W  base/source
//  o_uop_off        out  OFF_W  signed immediate byte offset
//  o_uop_byte       out  1      byte access (SWPB only)
//  o_uop_usr        out  1      force user-bank for rd (STM^ or LDM^ without PC)
//  o_uop_s          out  1      S-flag on final MOV PC (CPSR<=SPSR)
//  o_pass_instr     out  32     raw instruction when op=PASS
//  o_stall_from_decode out 1    more micro-ops follow for the current instruction
//  o_irq, o_fiq     out  1      interrupt tags, asserted only on the first micro-op of an instruction
//  o_seq_idx        out  5      index of current micro-op within the sequence (0 = first)
// BEHAVIOUR
//  - Outputs combinational from state + i_instruction (zero latency); state updates on posedge when !i_stall.
//  - Reset/i_clear: state IDLE, list_ff=0, cnt_ff=0. Outputs then show the IDLE view of the input
//    (o_uop_valid=i_instruction_valid, o_stall_from_decode=0).
//  - States: IDLE, XFER, WB, WPC, SWP1, SWP2.
//  - IDLE, LDM/STM (instr[27:25]=100, valid): emit MOV DUMMY0,Rn; latch list, N=popcount;
//    o_stall=1; -> XFER.
//  - Start offset S0: IA=0, IB=+4, DA=-4N+4, DB=-4N.
//  - XFER: lowest remaining reg r (always ascending); emit LDR/STR r,[DUMMY0+S0+4*k], k = beat count.
//    Clear bit r.
//  - XFER, load with r=PC_IDX: rd=DUMMY1.
//  - XFER, S bit set and (store or PC not in list): o_uop_usr=1.
//  - Last beat -> WB if W=1 and not (load and Rn in list); else -> WPC if load with PC in list; else IDLE.
//  - WB: ADD Rn,DUMMY0,+/-4N -> WPC if load with PC in list, else IDLE.
//  - WPC: MOV PC,DUMMY1 with o_uop_s=S -> IDLE.
//  - Empty list (N=0): one NOP micro-op, no transfer, no writeback -> IDLE.
//  - SWP (27:23=00010, 21:20=00, 7:4=1001): IDLE emits LDR DUMMY0,[Rn+0]; SWP1: STR Rm,[Rn+0];
//    SWP2: MOV Rd,DUMMY0. o_uop_byte=instr[22] on both memory ops.
//  - Other instructions: op=PASS, o_pass_instr=i_instruction, no stall.
//  - o_stall_from_decode=0 exactly on the final micro-op of a sequence (and on PASS).
//  - o_seq_idx increments per accepted micro-op; 0 in IDLE.
//  - i_clear mid-sequence aborts immediately (no WB/WPC issued). i_stall freezes state and list;
//    o_irq/o_fiq still only in IDLE.
//  - If i_instruction_valid=0 in IDLE: o_uop_valid=0, state unchanged.
// TESTING
//  - STMIA R0!,{R1,R2,R5}: MOV D0,R0; STR R1 +0; STR R2 +4; STR R5 +8; ADD R0,D0,+12.
//    Stall=1,1,1,1,0.
//  - LDMDB R3,{R4,PC}^ no W: MOV; LDR R4 off -8; LDR D1 off -4; MOV PC,D1 s=1. usr=0 throughout.
//  - LDMIA R2!,{R1,R2}: two LDRs (+0,+4), no ADD (base in list); stall drops on second LDR.
//  - SWPB R1,R2,[R3]: LDR D0,[R3] byte=1; STR R2,[R3] byte=1; MOV R1,D0.
//    irq=1 on input is seen only on beat 0.
//  - STMIB^ {R8,R13} with i_stall high 3 cycles on beat 1: output held; offsets +4,+8; usr=1 both.
//  - i_clear during beat 2 of a 5-reg LDM: next cycle IDLE, list cleared, next input passes through.

Source files
------------

// File: rtl/zap_predecode_uop_sequencer.sv
// Cracks LDM/STM/SWP into one decoded micro-op per cycle; everything else passes through raw.
// Zero latency (outputs combinational from state + instruction); i_stall freezes state, i_clear flushes to IDLE.
module zap_predecode_uop_sequencer #(
    parameter int LIST_W = 16,
    parameter int REG_W  = 6,
    parameter int DUMMY0 = 16,
    parameter int DUMMY1 = 17,
    parameter int PC_IDX = 15,
    parameter int OFF_W  = 9
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [31:0]        i_instruction,
    input  logic               i_instruction_valid,
    input  logic               i_irq,
    input  logic               i_fiq,
    input  logic               i_stall,
    input  logic               i_clear,
    output logic               o_uop_valid,
    output logic [2:0]         o_uop_op,
    output logic [3:0]         o_uop_cc,
    output logic [REG_W-1:0]   o_uop_rd,
    output logic [REG_W-1:0]   o_uop_rn,
    output logic [OFF_W-1:0]   o_uop_off,
    output logic               o_uop_byte,
    output logic               o_uop_usr,
    output logic               o_uop_s,
    output logic [31:0]        o_pass_instr,
    output logic               o_stall_from_decode,
    output logic               o_irq,
    output logic               o_fiq,
    output logic [4:0]         o_seq_idx
);

    localparam int IDX_W = $clog2(LIST_W);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_MOV  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_LDR  = 3'd3;
    localparam logic [2:0] OP_STR  = 3'd4;
    localparam logic [2:0] OP_PASS = 3'd7;

    localparam logic [REG_W-1:0]  D0_R  = REG_W'(DUMMY0);
    localparam logic [REG_W-1:0]  D1_R  = REG_W'(DUMMY1);
    localparam logic [REG_W-1:0]  PC_R  = REG_W'(PC_IDX);
    localparam logic [IDX_W-1:0]  PC_I  = IDX_W'(PC_IDX);
    localparam logic [LIST_W-1:0] ONE_L = LIST_W'(1);
    localparam logic [OFF_W-1:0]  FOUR  = OFF_W'(4);

    typedef enum logic [2:0] {S_IDLE, S_XFER, S_WB, S_WPC, S_SWP1, S_SWP2} state_t;

    state_t            state_ff, state_nxt;
    logic [LIST_W-1:0] list_ff, list_nxt;
    logic [4:0]        cnt_ff, cnt_nxt;
    logic [4:0]        seq_ff, seq_nxt;

    // Instruction fields; the instruction is held stable by fetch for the whole sequence.
    logic              is_ldm_stm, is_swp;
    logic              p_bit, u_bit, s_bit, w_bit, l_bit;
    logic [3:0]        rn4;
    logic [REG_W-1:0]  rn_r, rd_r, rm_r;
    logic [LIST_W-1:0] list_in;
    logic [OFF_W-1:0]  n_pop, n4, start_off, xfer_off;
    logic              pc_in_list, rn_in_list, do_wb, do_wpc;
    logic [IDX_W-1:0]  low_idx;
    logic              last_beat;

    always_comb begin
        is_ldm_stm = (i_instruction[27:25] == 3'b100);
        is_swp     = (i_instruction[27:23] == 5'b00010) && (i_instruction[21:20] == 2'b00)
                     && (i_instruction[7:4] == 4'b1001);
        p_bit      = i_instruction[24];
        u_bit      = i_instruction[23];
        s_bit      = i_instruction[22];
        w_bit      = i_instruction[21];
        l_bit      = i_instruction[20];
        rn4        = i_instruction[19:16];
        rn_r       = REG_W'(i_instruction[19:16]);
        rd_r       = REG_W'(i_instruction[15:12]);
        rm_r       = REG_W'(i_instruction[3:0]);
        list_in    = i_instruction[LIST_W-1:0];
        pc_in_list = list_in[PC_IDX];
        rn_in_list = list_in[rn4];
        do_wb      = w_bit && !(l_bit && rn_in_list);
        do_wpc     = l_bit && pc_in_list;

        n_pop = '0;
        for (int i = 0; i < LIST_W; i++) begin
            n_pop = n_pop + OFF_W'(list_in[i]);
        end
        n4 = n_pop << 2;

        unique case ({p_bit, u_bit})
            2'b01:   start_off = '0;
            2'b11:   start_off = FOUR;
            2'b00:   start_off = FOUR - n4;
            default: start_off = '0 - n4;
        endcase
        xfer_off = start_off + OFF_W'({cnt_ff, 2'b00});

        // Lowest set bit wins: transfers always go in ascending register order.
        low_idx = '0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (list_ff[i]) low_idx = IDX_W'(i);
        end
        last_beat = ((list_ff & (list_ff - ONE_L)) == '0);
    end

    always_comb begin
        o_uop_valid         = 1'b1;
        o_uop_op            = OP_NOP;
        o_uop_cc            = i_instruction[31:28];
        o_uop_rd            = '0;
        o_uop_rn            = '0;
        o_uop_off           = '0;
        o_uop_byte          = 1'b0;
        o_uop_usr           = 1'b0;
        o_uop_s             = 1'b0;
        o_pass_instr        = i_instruction;
        o_stall_from_decode = 1'b0;
        o_irq               = 1'b0;
        o_fiq               = 1'b0;
        o_seq_idx           = seq_ff;
        state_nxt           = state_ff;
        list_nxt            = list_ff;
        cnt_nxt             = cnt_ff;

        unique case (state_ff)
            S_IDLE: begin
                o_uop_valid = i_instruction_valid;
                o_irq       = i_irq && i_instruction_valid;
                o_fiq       = i_fiq && i_instruction_valid;
                if (is_ldm_stm) begin
                    if (n_pop != '0) begin
                        o_uop_op            = OP_MOV;
                        o_uop_rd            = D0_R;
                        o_uop_rn            = rn_r;
                        o_stall_from_decode = i_instruction_valid;
                        if (i_instruction_valid) begin
                            state_nxt = S_XFER;
                            list_nxt  = list_in;
                        end
                    end
                end else if (is_swp) begin
                    o_uop_op            = OP_LDR;
                    o_uop_rd            = D0_R;
                    o_uop_rn            = rn_r;
                    o_uop_byte          = s_bit;
                    o_stall_from_decode = i_instruction_valid;
                    if (i_instruction_valid) state_nxt = S_SWP1;
                end else begin
                    o_uop_op = OP_PASS;
                end
            end
            S_XFER: begin
                o_uop_op  = l_bit ? OP_LDR : OP_STR;
                o_uop_rd  = (l_bit && low_idx == PC_I) ? D1_R : REG_W'(low_idx);
                o_uop_rn  = D0_R;
                o_uop_off = xfer_off;
                o_uop_usr = s_bit && (!l_bit || !pc_in_list);
                list_nxt  = list_ff & ~(ONE_L << low_idx);
                cnt_nxt   = cnt_ff + 5'd1;
                if (!last_beat) begin
                    o_stall_from_decode = 1'b1;
                end else if (do_wb) begin
                    o_stall_from_decode = 1'b1;
                    state_nxt           = S_WB;
                end else if (do_wpc) begin
                    o_stall_from_decode = 1'b1;
                    state_nxt           = S_WPC;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_WB: begin
                o_uop_op            = OP_ADD;
                o_uop_rd            = rn_r;
                o_uop_rn            = D0_R;
                o_uop_off           = u_bit ? n4 : ('0 - n4);
                o_stall_from_decode = do_wpc;
                state_nxt           = do_wpc ? S_WPC : S_IDLE;
            end
            S_WPC: begin
                o_uop_op  = OP_MOV;
                o_uop_rd  = PC_R;
                o_uop_rn  = D1_R;
                o_uop_s   = s_bit;
                state_nxt = S_IDLE;
            end
            S_SWP1: begin
                o_uop_op            = OP_STR;
                o_uop_rd            = rm_r;
                o_uop_rn            = rn_r;
                o_uop_byte          = s_bit;
                o_stall_from_decode = 1'b1;
                state_nxt           = S_SWP2;
            end
            default: begin
                o_uop_op  = OP_MOV;
                o_uop_rd  = rd_r;
                o_uop_rn  = D0_R;
                state_nxt = S_IDLE;
            end
        endcase

        if (state_nxt == S_IDLE) begin
            list_nxt = '0;
            cnt_nxt  = '0;
            seq_nxt  = '0;
        end else begin
            seq_nxt  = seq_ff + 5'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            state_ff <= S_IDLE;
            list_ff  <= '0;
            cnt_ff   <= '0;
            seq_ff   <= '0;
        end else if (!i_stall) begin
            state_ff <= state_nxt;
            list_ff  <= list_nxt;
            cnt_ff   <= cnt_nxt;
            seq_ff   <= seq_nxt;
        end
    end

endmodule
